my_rx_control: RTL and testbench

- Receive-direction counterpart of the TX sample path.
- Accepts 32-bit samples from the DSP RX core on `strobe` while `run` is high and buffers them in an internal FIFO.
- Frames the samples into packets: header word `0xdead`, then header word `0xcafe`, then payload.
- Streams the packets into the buffer pool write interface with sop/eop flags and ready/ready handshake.
- Reports overruns in packet headers.

---
 rtl/my_rx_control_pkg.sv | 36 +++
 rtl/my_rx_control_fifo.sv | 56 +++++
 rtl/my_rx_control.sv | 160 ++++++++++++++++
 tb/tb_my_rx_control.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_rx_control_pkg.sv
// Shared constants for the RX sample framing path: header sync words, settings
// register map, framing FSM states and header flag bit positions.
package my_rx_control_pkg;

    localparam logic [15:0] HDR_SYNC0 = 16'hdead;
    localparam logic [15:0] HDR_SYNC1 = 16'hcafe;

    localparam int unsigned DSP_CORE_RX_BASE = 160;
    localparam int unsigned REG_PKT_LEN      = 0;
    localparam int unsigned REG_CTRL         = 1;

    localparam int unsigned HDR_OVF = 0;
    localparam int unsigned HDR_SOB = 1;
    localparam int unsigned HDR_EOB = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_PAYLOAD = 3'd3
    } rx_state_e;

    // A zero length would never close a packet; anything above the FIFO depth
    // could never become eligible.
    function automatic logic [15:0] clamp_pkt_len(input logic [15:0] req,
                                                  input int unsigned log2_depth);
        logic [31:0] max_len;
        max_len = 32'd1 << log2_depth;
        if (req == '0)
            return 16'd1;
        if ({16'd0, req} > max_len)
            return max_len[15:0];
        return req;
    endfunction

endpackage

// File: rtl/my_rx_control_fifo.sv
// Show-ahead sample FIFO: the head word is readable combinationally while
// non-empty, so the framer can present it directly as payload.
module fifo_cascade #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] datain,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] dataout,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic [15:0]      occupied
);

    localparam int unsigned DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SIZE-1:0]  wr_ptr_q, rd_ptr_q;
    logic [SIZE:0]    count_q;
    logic             do_wr, do_rd;

    assign dst_rdy_o = (count_q != (SIZE+1)'(DEPTH));
    assign src_rdy_o = (count_q != '0);
    assign do_wr     = src_rdy_i & dst_rdy_o;
    assign do_rd     = dst_rdy_i & src_rdy_o;
    assign dataout   = mem_q[rd_ptr_q];
    assign occupied  = 16'(count_q);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem_q[wr_ptr_q] <= datain;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_q <= wr_ptr_q + SIZE'(1);
            if (do_rd)
                rd_ptr_q <= rd_ptr_q + SIZE'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (SIZE+1)'(1);
                2'b01:   count_q <= count_q - (SIZE+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/my_rx_control.sv
// RX sample framer: buffers DSP samples and emits dead/cafe-headed packets
// into the buffer pool write port, reporting overrun and burst edges.
module my_rx_control
    import my_rx_control_pkg::*;
#(
    parameter int unsigned FIFOSIZE = 10,
    parameter int unsigned SET_BASE = DSP_CORE_RX_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] sample,
    input  logic        run,
    input  logic        strobe,
    output logic        overrun,
    output logic [31:0] wr_dat_o,
    output logic [3:0]  wr_flags_o,
    output logic        wr_ready_o,
    input  logic        wr_ready_i,
    output logic [15:0] fifo_occupied,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [15:0] packet_count,
    output logic [31:0] debug
);

    rx_state_e   state_q;
    logic [15:0] pkt_len_q, len_q, cnt_q, packet_count_q;
    logic [12:0] seq_q;
    logic        flush_q, run_d_q, overrun_q;
    logic        ovf_q, sob_q, eob_q;
    logic        fifo_wr, fifo_rd, fifo_has_space, fifo_has_data, drop, xfer;
    logic [31:0] fifo_dout;
    logic [2:0]  hdr_flags;
    logic        unused_set_bits;

    assign unused_set_bits = ^set_data[31:16];

    assign drop       = strobe & run & fifo_full;
    assign fifo_wr    = strobe & run & ~fifo_full;
    assign wr_ready_o = (state_q != ST_IDLE) & ~flush_q;
    assign xfer       = wr_ready_o & wr_ready_i;
    assign fifo_rd    = xfer & (state_q == ST_PAYLOAD);
    assign fifo_full  = ~fifo_has_space;
    assign fifo_empty = ~fifo_has_data;

    fifo_cascade #(.WIDTH(32), .SIZE(FIFOSIZE)) u_fifo (
        .clk       (clk),
        .reset     (rst),
        .clear     (flush_q | rst),
        .datain    (sample),
        .src_rdy_i (fifo_wr),
        .dst_rdy_o (fifo_has_space),
        .dataout   (fifo_dout),
        .src_rdy_o (fifo_has_data),
        .dst_rdy_i (fifo_rd),
        .occupied  (fifo_occupied)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_len_q <= 16'd256;
            flush_q   <= 1'b0;
            run_d_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            flush_q   <= set_stb && (set_addr == 8'(SET_BASE + REG_CTRL)) && set_data[0];
            if (set_stb && (set_addr == 8'(SET_BASE + REG_PKT_LEN)))
                pkt_len_q <= clamp_pkt_len(set_data[15:0], FIFOSIZE);
            run_d_q   <= run;
            overrun_q <= drop;
        end
    end

    // Flush shares the reset path except that packet_count survives it.
    always_ff @(posedge clk) begin
        if (rst || flush_q) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            sob_q   <= 1'b0;
            eob_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            if (rst)
                packet_count_q <= '0;
        end else begin
            if (drop)
                ovf_q <= 1'b1;
            else if (xfer && state_q == ST_HDR0)
                ovf_q <= 1'b0;
            if (run && !run_d_q)
                sob_q <= 1'b1;
            else if (xfer && state_q == ST_HDR0)
                sob_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (fifo_occupied >= pkt_len_q) begin
                        state_q <= ST_HDR0;
                        len_q   <= pkt_len_q;
                        eob_q   <= ~run & (fifo_occupied == pkt_len_q);
                    end else if (!run && fifo_occupied != '0) begin
                        state_q <= ST_HDR0;
                        len_q   <= fifo_occupied;
                        eob_q   <= 1'b1;
                    end
                end
                ST_HDR0: if (xfer) state_q <= ST_HDR1;
                ST_HDR1: begin
                    if (xfer) begin
                        state_q <= ST_PAYLOAD;
                        cnt_q   <= len_q - 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == '0) begin
                            state_q        <= ST_IDLE;
                            seq_q          <= seq_q + 13'd1;
                            packet_count_q <= packet_count_q + 16'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Word/flags are decoded from registered state so they hold while stalled.
    always_comb begin
        hdr_flags          = '0;
        hdr_flags[HDR_OVF] = ovf_q;
        hdr_flags[HDR_SOB] = sob_q;
        hdr_flags[HDR_EOB] = eob_q;
        wr_dat_o           = '0;
        wr_flags_o         = '0;
        case (state_q)
            ST_HDR0: begin
                wr_dat_o      = {HDR_SYNC0, seq_q, hdr_flags};
                wr_flags_o[0] = 1'b1;
            end
            ST_HDR1: wr_dat_o = {HDR_SYNC1, len_q};
            ST_PAYLOAD: begin
                wr_dat_o      = fifo_dout;
                wr_flags_o[1] = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign overrun      = overrun_q;
    assign packet_count = packet_count_q;
    assign debug        = {20'b0, state_q, ovf_q, sob_q, eob_q, fifo_full, fifo_empty,
                           wr_ready_o, wr_ready_i, fifo_rd, fifo_wr};

endmodule

// File: tb/tb_my_rx_control.sv
// Directed bench for my_rx_control: framing, EOB on burst end, overrun,
// backpressure, flush and mid-packet reset.
module tb_my_rx_control;

    logic        clk = 1'b0;
    logic        rst, set_stb, run, strobe, wr_ready_i;
    logic [7:0]  set_addr;
    logic [31:0] set_data, sample;
    logic        overrun, wr_ready_o, fifo_full, fifo_empty;
    logic [31:0] wr_dat_o, debug;
    logic [3:0]  wr_flags_o;
    logic [15:0] fifo_occupied, packet_count;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    logic [33:0] xq[$];

    always #5 clk = ~clk;

    my_rx_control #(.FIFOSIZE(4), .SET_BASE(160)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .sample(sample), .run(run), .strobe(strobe), .overrun(overrun),
        .wr_dat_o(wr_dat_o), .wr_flags_o(wr_flags_o), .wr_ready_o(wr_ready_o),
        .wr_ready_i(wr_ready_i), .fifo_occupied(fifo_occupied), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .packet_count(packet_count), .debug(debug)
    );

    // Transfer log {eop, sop, data}, sampled mid-cycle before the edge that commits it.
    always @(negedge clk) begin
        if (wr_ready_o && wr_ready_i)
            xq.push_back({wr_flags_o[1:0], wr_dat_o});
        if (overrun)
            ovr_cnt++;
    end

    function automatic logic [33:0] w(input bit sop, input bit eop, input logic [31:0] d);
        return {eop, sop, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
        sample = '0; run = 1'b0; strobe = 1'b0; wr_ready_i = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        cyc();
        set_stb = 1'b0;
    endtask

    task automatic wait_xq(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (xq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wr_ready_o, wr_flags_o, wr_dat_o} !== 37'd0) begin
            failures++;
            $display("FAIL reset_wr got=%h want=0", {wr_ready_o, wr_flags_o, wr_dat_o});
        end
        checks++;
        if ({overrun, packet_count} !== 17'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h want=0", {overrun, packet_count});
        end
        checks++;
        if ({fifo_empty, fifo_full, fifo_occupied} !== {1'b1, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL reset_fifo got=%h want=%h", {fifo_empty, fifo_full, fifo_occupied},
                     {1'b1, 1'b0, 16'd0});
        end
        checks++;
        if (debug !== 32'h10) begin
            failures++;
            $display("FAIL reset_debug got=%h want=00000010", debug);
        end
    endtask

    task automatic test_basic();
        logic [33:0] e [12];
        int base;
        bit ok;
        e = '{w(1,0,32'hdead0002), w(0,0,32'hcafe0004), w(0,0,1), w(0,0,2), w(0,0,3), w(0,1,4),
              w(1,0,32'hdead0008), w(0,0,32'hcafe0004), w(0,0,5), w(0,0,6), w(0,0,7), w(0,1,8)};
        do_reset();
        set_reg(8'd160, 32'd4);
        wr_ready_i = 1'b1; run = 1'b1; base = xq.size();
        for (int i = 1; i <= 8; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        wait_xq(base + 12, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout got=%0d want=%0d", xq.size() - base, 12);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (xq[base+i] !== e[i]) begin
                    failures++;
                    $display("FAIL basic_word[%0d] got=%h want=%h", i, xq[base+i], e[i]);
                end
            end
        end
        cyc();
        checks++;
        if (packet_count !== 16'd2) begin
            failures++;
            $display("FAIL basic_pktcnt got=%0d want=2", packet_count);
        end
        run = 1'b0;
    endtask

    task automatic test_eob();
        logic [33:0] e [10];
        int base;
        bit ok;
        e = '{w(1,0,32'hdead0002), w(0,0,32'hcafe0004), w(0,0,1), w(0,0,2), w(0,0,3), w(0,1,4),
              w(1,0,32'hdead000c), w(0,0,32'hcafe0002), w(0,0,5), w(0,1,6)};
        do_reset();
        set_reg(8'd160, 32'd4);
        wr_ready_i = 1'b1; run = 1'b1; base = xq.size();
        for (int i = 1; i <= 6; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0; run = 1'b0;
        wait_xq(base + 10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL eob_timeout got=%0d want=%0d", xq.size() - base, 10);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (xq[base+i] !== e[i]) begin
                    failures++;
                    $display("FAIL eob_word[%0d] got=%h want=%h", i, xq[base+i], e[i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int base, ovr0;
        bit ok;
        do_reset();
        set_reg(8'd160, 32'd16);
        wr_ready_i = 1'b0; run = 1'b1; base = xq.size(); ovr0 = ovr_cnt;
        for (int i = 1; i <= 20; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        cyc(); cyc();
        checks++;
        if (ovr_cnt - ovr0 !== 4) begin
            failures++;
            $display("FAIL ovr_pulses got=%0d want=4", ovr_cnt - ovr0);
        end
        checks++;
        if ({fifo_full, fifo_occupied} !== {1'b1, 16'd16}) begin
            failures++;
            $display("FAIL ovr_full got=%h want=%h", {fifo_full, fifo_occupied}, {1'b1, 16'd16});
        end
        checks++;
        if ({wr_ready_o, wr_dat_o} !== {1'b1, 32'hdead0003}) begin
            failures++;
            $display("FAIL ovr_stalled_hdr got=%h want=%h", {wr_ready_o, wr_dat_o},
                     {1'b1, 32'hdead0003});
        end
        wr_ready_i = 1'b1;
        wait_xq(base + 18, ok);
        for (int i = 101; i <= 116; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        wait_xq(base + 36, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ovr_timeout got=%0d want=%0d", xq.size() - base, 36);
        end else begin
            checks++;
            if (xq[base] !== w(1,0,32'hdead0003)) begin
                failures++;
                $display("FAIL ovr_hdr0 got=%h want=%h", xq[base], w(1,0,32'hdead0003));
            end
            checks++;
            if (xq[base+1] !== w(0,0,32'hcafe0010)) begin
                failures++;
                $display("FAIL ovr_hdr1 got=%h want=%h", xq[base+1], w(0,0,32'hcafe0010));
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (xq[base+2+i] !== w(0, i == 15, 32'(i + 1))) begin
                    failures++;
                    $display("FAIL ovr_payload[%0d] got=%h want=%h", i, xq[base+2+i],
                             w(0, i == 15, 32'(i + 1)));
                end
            end
            checks++;
            if (xq[base+18] !== w(1,0,32'hdead0008)) begin
                failures++;
                $display("FAIL ovr_next_hdr got=%h want=%h", xq[base+18], w(1,0,32'hdead0008));
            end
            checks++;
            if (xq[base+35] !== w(0,1,32'd116)) begin
                failures++;
                $display("FAIL ovr_next_last got=%h want=%h", xq[base+35], w(0,1,32'd116));
            end
        end
        run = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [33:0] e [6];
        logic [31:0] pd;
        logic [3:0]  pf;
        bit stall, ok;
        int base, sops, eops;
        e = '{w(1,0,32'hdead0002), w(0,0,32'hcafe0004), w(0,0,32'h41), w(0,0,32'h42),
              w(0,0,32'h43), w(0,1,32'h44)};
        do_reset();
        set_reg(8'd160, 32'd4);
        run = 1'b1; base = xq.size();
        for (int i = 1; i <= 4; i++) begin
            strobe = 1'b1; sample = 32'h40 + 32'(i);
            cyc();
        end
        strobe = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr_ready_i = i[0];
            stall = wr_ready_o && !wr_ready_i;
            pd = wr_dat_o; pf = wr_flags_o;
            cyc();
            if (stall) begin
                checks++;
                if ({wr_dat_o, wr_flags_o} !== {pd, pf}) begin
                    failures++;
                    $display("FAIL bp_stable got=%h want=%h", {wr_dat_o, wr_flags_o}, {pd, pf});
                end
            end
        end
        wr_ready_i = 1'b1;
        wait_xq(base + 6, ok);
        cyc(); cyc();
        checks++;
        if (xq.size() - base !== 6) begin
            failures++;
            $display("FAIL bp_count got=%0d want=6", xq.size() - base);
        end else begin
            sops = 0; eops = 0;
            for (int i = 0; i < 6; i++) begin
                sops += int'(xq[base+i][32]);
                eops += int'(xq[base+i][33]);
                checks++;
                if (xq[base+i] !== e[i]) begin
                    failures++;
                    $display("FAIL bp_word[%0d] got=%h want=%h", i, xq[base+i], e[i]);
                end
            end
            checks++;
            if (sops != 1 || eops != 1) begin
                failures++;
                $display("FAIL bp_sop_eop got=%0d/%0d want=1/1", sops, eops);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_flush();
        int base;
        bit ok;
        do_reset();
        set_reg(8'd160, 32'd4);
        wr_ready_i = 1'b1; run = 1'b1; base = xq.size();
        for (int i = 11; i <= 14; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        wait_xq(base + 4, ok);
        wr_ready_i = 1'b0;
        set_reg(8'd161, 32'd1);
        wr_ready_i = 1'b1;
        checks++;
        if (wr_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b want=0", wr_ready_o);
        end
        cyc();
        checks++;
        if ({fifo_empty, wr_ready_o, packet_count} !== {1'b1, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL flush_state got=%h want=%h", {fifo_empty, wr_ready_o, packet_count},
                     {1'b1, 1'b0, 16'd0});
        end
        cyc(); cyc();
        checks++;
        if (xq.size() - base !== 4 || xq[base+3] !== w(0,0,32'd12)) begin
            failures++;
            $display("FAIL flush_truncate got=%0d/%h want=4/%h", xq.size() - base,
                     xq[xq.size()-1], w(0,0,32'd12));
        end
        for (int i = 21; i <= 24; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        wait_xq(base + 10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL flush_timeout got=%0d want=10", xq.size() - base);
        end else begin
            checks++;
            if (xq[base+4] !== w(1,0,32'hdead0000)) begin
                failures++;
                $display("FAIL flush_seq0 got=%h want=%h", xq[base+4], w(1,0,32'hdead0000));
            end
            checks++;
            if (xq[base+9] !== w(0,1,32'd24)) begin
                failures++;
                $display("FAIL flush_next_last got=%h want=%h", xq[base+9], w(0,1,32'd24));
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        do_reset();
        set_reg(8'd160, 32'd4);
        wr_ready_i = 1'b1; run = 1'b1; base = xq.size();
        for (int i = 1; i <= 4; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        wait_xq(base + 3, ok);
        rst = 1'b1;
        cyc();
        checks++;
        if ({wr_ready_o, wr_flags_o, wr_dat_o, overrun, packet_count} !== 54'd0) begin
            failures++;
            $display("FAIL rstmid_out got=%h want=0",
                     {wr_ready_o, wr_flags_o, wr_dat_o, overrun, packet_count});
        end
        checks++;
        if ({fifo_empty, fifo_full, fifo_occupied} !== {1'b1, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL rstmid_fifo got=%h want=%h", {fifo_empty, fifo_full, fifo_occupied},
                     {1'b1, 1'b0, 16'd0});
        end
        rst = 1'b0; run = 1'b0;
        cyc();
        run = 1'b1;
        for (int i = 31; i <= 46; i++) begin
            strobe = 1'b1; sample = 32'(i);
            cyc();
        end
        strobe = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (wr_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pktlen_hold got=%b want=0", wr_ready_o);
        end
        base = xq.size();
        run = 1'b0;
        wait_xq(base + 2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_timeout got=%0d want=2", xq.size() - base);
        end else begin
            checks++;
            if ({xq[base], xq[base+1]} !== {w(1,0,32'hdead0006), w(0,0,32'hcafe0010)}) begin
                failures++;
                $display("FAIL rstmid_hdr got=%h_%h want=%h_%h", xq[base], xq[base+1],
                         w(1,0,32'hdead0006), w(0,0,32'hcafe0010));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_eob();
        test_overrun();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
